// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - 4-entry age-ordered integer reservation station
// Slot 0 is always the oldest op; grants compact the queue downward.
module int_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              dispatch_valid,
    input  logic [3:0]        dispatch_opcode,
    input  logic [DATA_W-1:0] dispatch_rsdata,
    input  logic [TAG_W-1:0]  dispatch_rstag,
    input  logic              dispatch_rsvalid,
    input  logic [DATA_W-1:0] dispatch_rtdata,
    input  logic [TAG_W-1:0]  dispatch_rttag,
    input  logic              dispatch_rtvalid,
    input  logic [TAG_W-1:0]  dispatch_rdtag,
    output logic              queue_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tagout,
    input  logic [DATA_W-1:0] cdb_out,
    output logic              ready_int,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] rsdata,
    output logic [DATA_W-1:0] rtdata,
    output logic [TAG_W-1:0]  rdtag,
    input  logic              issue_int
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] rsd;
        logic [TAG_W-1:0]  rst;
        logic              rsv;
        logic [DATA_W-1:0] rtd;
        logic [TAG_W-1:0]  rtt;
        logic              rtv;
        logic [TAG_W-1:0]  rdt;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    entry_t          snp   [DEPTH];
    entry_t          new_ent;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   wr_idx;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic            grant;
    logic            accept;

    // Downward scan so the lowest (oldest) ready slot wins.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count_q) && ent_q[i].rsv && ent_q[i].rtv) begin
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign ready_int  = sel_found;
    assign opcode     = sel_found ? ent_q[sel_idx].op  : '0;
    assign rsdata     = sel_found ? ent_q[sel_idx].rsd : '0;
    assign rtdata     = sel_found ? ent_q[sel_idx].rtd : '0;
    assign rdtag      = sel_found ? ent_q[sel_idx].rdt : '0;
    assign queue_full = (count_q == CW'(DEPTH));
    assign grant      = sel_found & issue_int;
    assign accept     = dispatch_valid & ~queue_full;

    // Incoming op, with operands that the same-cycle CDB already resolves.
    always_comb begin
        new_ent.op  = dispatch_opcode;
        new_ent.rsd = dispatch_rsdata;
        new_ent.rst = dispatch_rstag;
        new_ent.rsv = dispatch_rsvalid;
        new_ent.rtd = dispatch_rtdata;
        new_ent.rtt = dispatch_rttag;
        new_ent.rtv = dispatch_rtvalid;
        new_ent.rdt = dispatch_rdtag;
        if (cdb_valid && !dispatch_rsvalid && (dispatch_rstag == cdb_tagout)) begin
            new_ent.rsd = cdb_out;
            new_ent.rsv = 1'b1;
        end
        if (cdb_valid && !dispatch_rtvalid && (dispatch_rttag == cdb_tagout)) begin
            new_ent.rtd = cdb_out;
            new_ent.rtv = 1'b1;
        end
    end

    // Snoop in place first, then shift, so captured operands travel with their entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp[i] = ent_q[i];
            if (cdb_valid && (CW'(i) < count_q)) begin
                if (!ent_q[i].rsv && (ent_q[i].rst == cdb_tagout)) begin
                    snp[i].rsd = cdb_out;
                    snp[i].rsv = 1'b1;
                end
                if (!ent_q[i].rtv && (ent_q[i].rtt == cdb_tagout)) begin
                    snp[i].rtd = cdb_out;
                    snp[i].rtv = 1'b1;
                end
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = snp[i];
        end
        if (grant) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= sel_idx) begin
                    ent_d[i] = snp[i + 1];
                end
            end
            ent_d[DEPTH - 1] = '0;
        end

        wr_idx = grant ? (count_q - CW'(1)) : count_q;
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    ent_d[i] = new_ent;
                end
            end
        end

        count_d = count_q + CW'(accept) - CW'(grant);

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - scoreboard bench for int_issue_queue
module tb_int_issue_queue;

    typedef logic [4+32+32+6-1:0] item_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        dispatch_valid;
    logic [3:0]  dispatch_opcode;
    logic [31:0] dispatch_rsdata;
    logic [5:0]  dispatch_rstag;
    logic        dispatch_rsvalid;
    logic [31:0] dispatch_rtdata;
    logic [5:0]  dispatch_rttag;
    logic        dispatch_rtvalid;
    logic [5:0]  dispatch_rdtag;
    logic        queue_full;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        ready_int;
    logic [3:0]  opcode;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic [5:0]  rdtag;
    logic        issue_int;

    int    vectors;
    int    miscompares;
    item_t sb[$];
    item_t exp;
    item_t obs;

    assign obs = {opcode, rsdata, rtdata, rdtag};

    int_issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rstag(dispatch_rstag),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rttag(dispatch_rttag), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_rdtag(dispatch_rdtag), .queue_full(queue_full),
        .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
        .ready_int(ready_int), .opcode(opcode), .rsdata(rsdata), .rtdata(rtdata),
        .rdtag(rdtag), .issue_int(issue_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic item_t mk(input logic [3:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [5:0] rd);
        return {op, rs, rt, rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid   = 1'b0;
        dispatch_opcode  = '0;
        dispatch_rsdata  = '0;
        dispatch_rstag   = '0;
        dispatch_rsvalid = 1'b0;
        dispatch_rtdata  = '0;
        dispatch_rttag   = '0;
        dispatch_rtvalid = 1'b0;
        dispatch_rdtag   = '0;
        cdb_valid        = 1'b0;
        cdb_tagout       = '0;
        cdb_out          = '0;
        issue_int        = 1'b0;
        flush            = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] rsd, input logic [5:0] rst,
                        input logic rsv, input logic [31:0] rtd, input logic [5:0] rtt,
                        input logic rtv, input logic [5:0] rd);
        dispatch_valid   = 1'b1;
        dispatch_opcode  = op;
        dispatch_rsdata  = rsd;
        dispatch_rstag   = rst;
        dispatch_rsvalid = rsv;
        dispatch_rtdata  = rtd;
        dispatch_rttag   = rtt;
        dispatch_rtvalid = rtv;
        dispatch_rdtag   = rd;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (ready_int !== 1'b0 || queue_full !== 1'b0 || obs !== '0 || dut.count_q !== 3'd0) begin
            miscompares++;
            $display("FAIL reset: ready=%0b full=%0b out=%h count=%0d expected all zero",
                     ready_int, queue_full, obs, dut.count_q);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ready_dispatch();
        disp(4'd0, 32'hA, 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 6'h0E);
        issue_int = 1'b1;
        sb.push_back(mk(4'd0, 32'hA, 32'h5, 6'h0E));
        tick();
        dispatch_valid = 1'b0;
        exp = sb.pop_front();
        vectors++;
        if (ready_int !== 1'b1 || obs !== exp) begin
            miscompares++;
            $display("FAIL ready_dispatch: ready=%0b out=%h expected ready=1 out=%h", ready_int, obs, exp);
        end
        tick();
        issue_int = 1'b0;
        vectors++;
        if (ready_int !== 1'b0 || dut.count_q !== 3'd0) begin
            miscompares++;
            $display("FAIL ready_dispatch_drain: ready=%0b count=%0d expected 0 0", ready_int, dut.count_q);
        end
    endtask

    task automatic test_wakeup();
        disp(4'd2, 32'hDEAD, 6'h03, 1'b0, 32'h5, 6'd0, 1'b1, 6'h0B);
        sb.push_back(mk(4'd2, 32'hF, 32'h5, 6'h0B));
        tick();
        idle();
        vectors++;
        if (ready_int !== 1'b0) begin
            miscompares++;
            $display("FAIL wakeup_pending: ready=%0b expected 0", ready_int);
        end
        cdb_valid = 1'b1; cdb_tagout = 6'h03; cdb_out = 32'hF;
        #1;
        vectors++;
        if (ready_int !== 1'b0) begin
            miscompares++;
            $display("FAIL wakeup_same_cycle: ready=%0b expected 0", ready_int);
        end
        tick();
        idle();
        exp = sb.pop_front();
        vectors++;
        if (ready_int !== 1'b1 || obs !== exp) begin
            miscompares++;
            $display("FAIL wakeup: ready=%0b out=%h expected ready=1 out=%h", ready_int, obs, exp);
        end
        issue_int = 1'b1;
        tick();
        issue_int = 1'b0;
    endtask

    task automatic test_age_order();
        disp(4'd9, 32'h0, 6'h11, 1'b0, 32'h1, 6'd0, 1'b1, 6'h21);
        tick();
        disp(4'd4, 32'h2, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1, 6'h22);
        tick();
        disp(4'd5, 32'h4, 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 6'h23);
        tick();
        idle();
        sb.push_back(mk(4'd4, 32'h2, 32'h3, 6'h22));
        sb.push_back(mk(4'd9, 32'h99, 32'h1, 6'h21));
        sb.push_back(mk(4'd5, 32'h4, 32'h5, 6'h23));
        exp = sb.pop_front();
        vectors++;
        if (ready_int !== 1'b1 || obs !== exp) begin
            miscompares++;
            $display("FAIL age_first: ready=%0b out=%h expected ready=1 out=%h", ready_int, obs, exp);
        end
        issue_int = 1'b1;
        tick();
        issue_int = 1'b0;
        vectors++;
        if (ready_int !== 1'b1 || obs !== mk(4'd5, 32'h4, 32'h5, 6'h23)) begin
            miscompares++;
            $display("FAIL age_after_grant: ready=%0b out=%h expected C", ready_int, obs);
        end
        cdb_valid = 1'b1; cdb_tagout = 6'h11; cdb_out = 32'h99;
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            exp = sb.pop_front();
            vectors++;
            if (ready_int !== 1'b1 || obs !== exp) begin
                miscompares++;
                $display("FAIL age_order_%0d: ready=%0b out=%h expected ready=1 out=%h", k, ready_int, obs, exp);
            end
            issue_int = 1'b1;
            tick();
            issue_int = 1'b0;
        end
        vectors++;
        if (ready_int !== 1'b0 || dut.count_q !== 3'd0) begin
            miscompares++;
            $display("FAIL age_drain: ready=%0b count=%0d expected 0 0", ready_int, dut.count_q);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 5; k++) begin
            disp(4'(k + 1), 32'(k * 16 + 1), 6'd0, 1'b1, 32'(k * 16 + 2), 6'd0, 1'b1, 6'(k + 40));
            if (k < 4) sb.push_back(mk(4'(k + 1), 32'(k * 16 + 1), 32'(k * 16 + 2), 6'(k + 40)));
            tick();
            vectors++;
            if (queue_full !== (k >= 3)) begin
                miscompares++;
                $display("FAIL full_%0d: queue_full=%0b expected %0b", k, queue_full, (k >= 3));
            end
        end
        vectors++;
        if (dut.count_q !== 3'd4) begin
            miscompares++;
            $display("FAIL full_drop: count=%0d expected 4", dut.count_q);
        end
        disp(4'd15, 32'h77, 6'd0, 1'b1, 32'h78, 6'd0, 1'b1, 6'h3F);
        exp = sb.pop_front();
        vectors++;
        if (ready_int !== 1'b1 || obs !== exp) begin
            miscompares++;
            $display("FAIL full_grant: ready=%0b out=%h expected ready=1 out=%h", ready_int, obs, exp);
        end
        issue_int = 1'b1;
        tick();
        idle();
        vectors++;
        if (dut.count_q !== 3'd3 || queue_full !== 1'b0) begin
            miscompares++;
            $display("FAIL full_grant_dispatch: count=%0d full=%0b expected 3 0", dut.count_q, queue_full);
        end
        for (int k = 0; k < 3; k++) begin
            exp = sb.pop_front();
            vectors++;
            if (ready_int !== 1'b1 || obs !== exp) begin
                miscompares++;
                $display("FAIL full_drain_%0d: ready=%0b out=%h expected ready=1 out=%h", k, ready_int, obs, exp);
            end
            issue_int = 1'b1;
            tick();
            issue_int = 1'b0;
        end
    endtask

    task automatic test_bypass();
        disp(4'd7, 32'h1, 6'd0, 1'b1, 32'h55, 6'h08, 1'b0, 6'h0C);
        cdb_valid = 1'b1; cdb_tagout = 6'h08; cdb_out = 32'h6;
        sb.push_back(mk(4'd7, 32'h1, 32'h6, 6'h0C));
        tick();
        idle();
        exp = sb.pop_front();
        vectors++;
        if (ready_int !== 1'b1 || obs !== exp) begin
            miscompares++;
            $display("FAIL bypass: ready=%0b out=%h expected ready=1 out=%h", ready_int, obs, exp);
        end
        issue_int = 1'b1;
        tick();
        issue_int = 1'b0;
    endtask

    task automatic test_snoop_shift();
        disp(4'd0, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1, 6'h31);
        tick();
        disp(4'd2, 32'h0, 6'h2A, 1'b0, 32'h0, 6'h2A, 1'b0, 6'h32);
        tick();
        idle();
        sb.push_back(mk(4'd0, 32'h1, 32'h2, 6'h31));
        sb.push_back(mk(4'd2, 32'h1234, 32'h1234, 6'h32));
        exp = sb.pop_front();
        vectors++;
        if (ready_int !== 1'b1 || obs !== exp) begin
            miscompares++;
            $display("FAIL snoop_shift_head: ready=%0b out=%h expected ready=1 out=%h", ready_int, obs, exp);
        end
        issue_int = 1'b1;
        cdb_valid = 1'b1; cdb_tagout = 6'h2A; cdb_out = 32'h1234;
        tick();
        idle();
        exp = sb.pop_front();
        vectors++;
        if (ready_int !== 1'b1 || obs !== exp) begin
            miscompares++;
            $display("FAIL snoop_shift: ready=%0b out=%h expected ready=1 out=%h", ready_int, obs, exp);
        end
        issue_int = 1'b1;
        tick();
        issue_int = 1'b0;
        vectors++;
        if (dut.count_q !== 3'd0) begin
            miscompares++;
            $display("FAIL snoop_shift_drain: count=%0d expected 0", dut.count_q);
        end
    endtask

    task automatic test_flush_reset();
        disp(4'd1, 32'h10, 6'd0, 1'b1, 32'h11, 6'd0, 1'b1, 6'h01);
        tick();
        disp(4'd2, 32'h0, 6'h30, 1'b0, 32'h12, 6'd0, 1'b1, 6'h02);
        tick();
        disp(4'd4, 32'h13, 6'd0, 1'b1, 32'h14, 6'd0, 1'b1, 6'h03);
        tick();
        disp(4'd5, 32'h15, 6'd0, 1'b1, 32'h16, 6'd0, 1'b1, 6'h04);
        cdb_valid = 1'b1; cdb_tagout = 6'h30; cdb_out = 32'h99;
        issue_int = 1'b1;
        flush = 1'b1;
        tick();
        idle();
        vectors++;
        if (dut.count_q !== 3'd0 || ready_int !== 1'b0 || obs !== '0 || queue_full !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: count=%0d ready=%0b out=%h full=%0b expected all zero",
                     dut.count_q, ready_int, obs, queue_full);
        end
        disp(4'd6, 32'h20, 6'd0, 1'b1, 32'h21, 6'd0, 1'b1, 6'h05);
        tick();
        idle();
        vectors++;
        if (ready_int !== 1'b1 || obs !== mk(4'd6, 32'h20, 32'h21, 6'h05)) begin
            miscompares++;
            $display("FAIL pre_reset: ready=%0b out=%h expected op 6 presented", ready_int, obs);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (ready_int !== 1'b0 || obs !== '0 || dut.count_q !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset: ready=%0b out=%h count=%0d expected all zero",
                     ready_int, obs, dut.count_q);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_age_order();
        test_full();
        test_bypass();
        test_snoop_shift();
        test_flush_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
